// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words tagged with a byte address.
// Optional macro IMM_CHECK_EN rejects immediates that would not survive re-decoding.
module inst_encoder #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [31:0]       enc_inst;
    logic              op_ok;
    logic              imm_ok;
    logic              is_shift;
    logic              accept;
    logic              legal;
    logic [ADDR_W-1:0] addr_base;

    assign is_shift = (in_op == OP_OPIMM) && (in_funct3 == 3'b001 || in_funct3 == 3'b101);

    always_comb begin
        enc_inst = '0;
        op_ok    = 1'b1;
        case (in_op)
            OP_OP:     enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            OP_OPIMM: begin
                if (is_shift)
                    enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                else
                    enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
            OP_LOAD, OP_JALR:
                       enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            OP_STORE:  enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            OP_BRANCH: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:1], in_imm[11], in_op};
            OP_LUI, OP_AUIPC:
                       enc_inst = {in_imm[31:12], in_rd, in_op};
            OP_JAL:    enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            default:   op_ok = 1'b0;
        endcase
    end

`ifdef IMM_CHECK_EN
    // True when bits [31:b] are all copies of bit b.
    function automatic logic sext_ok(input logic [31:0] v, input int b);
        logic [31:0] s;
        s = $signed(v) >>> b;
        return (s == '0) || (s == '1);
    endfunction

    always_comb begin
        imm_ok = 1'b1;
        case (in_op)
            OP_OPIMM:  imm_ok = is_shift ? (in_imm[31:5] == '0) : sext_ok(in_imm, 11);
            OP_LOAD, OP_JALR, OP_STORE:
                       imm_ok = sext_ok(in_imm, 11);
            OP_BRANCH: imm_ok = sext_ok(in_imm, 12) && !in_imm[0];
            OP_JAL:    imm_ok = sext_ok(in_imm, 20) && !in_imm[0];
            OP_LUI, OP_AUIPC:
                       imm_ok = (in_imm[11:0] == '0);
            default:   imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign legal     = accept && op_ok && imm_ok;
    assign addr_base = addr_load ? addr_value : addr_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_addr_d  = out_addr_q;
        err_d       = accept && !legal;
        err_cnt_d   = err_cnt_q;
        addr_d      = addr_base;
        if (accept) begin
            out_valid_d = legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (legal) begin
            out_inst_d = enc_inst;
            out_addr_d = addr_base;
            addr_d     = addr_base + ADDR_W'(4);
        end
        // Rejects saturate so a long stream of bad bundles cannot wrap back to zero.
        if (err_d && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            addr_q      <= RESET_ADDR;
        end else begin
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, handshake, address and reject behaviour.
module tb_inst_encoder;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_op;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_value;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [7:0]        err_cnt;

    int total = 0;
    int bad   = 0;

    inst_encoder #(.ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .addr_load(addr_load), .addr_value(addr_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_funct3 = f3;
        in_funct7 = f7;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        addr_load = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        in_op = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        addr_value = '0;
        do_reset();

        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step(); idle();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_inst", out_inst, 32'h00500093);
        chk("addi_addr", 32'(out_addr), 32'd0);

        // add then sw back to back
        do_reset();
        drive(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        chk("add_inst", out_inst, 32'h002081B3);
        chk("add_addr", 32'(out_addr), 32'd0);
        drive(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        step(); idle();
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_inst", out_inst, 32'h0020A423);
        chk("sw_addr", 32'(out_addr), 32'd4);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // jal x1,+8 held under backpressure; a waiting addi must not slip in
        do_reset();
        out_ready = 1'b0;
        drive(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        step();
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk("jal_hold_valid", 32'(out_valid), 32'd1);
            chk("jal_hold_inst", out_inst, 32'h008000EF);
            chk("jal_hold_ready", 32'(in_ready), 32'd0);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step(); idle();
        chk("post_bp_inst", out_inst, 32'h00500093);
        chk("post_bp_addr", 32'(out_addr), 32'd4);

        // illegal opcode
        do_reset();
        drive(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        step();
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd0);
        chk("ill_errcnt", 32'(err_cnt), 32'd1);
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step(); idle();
        chk("ill_err_pulse", 32'(err), 32'd0);
        chk("ill_next_valid", 32'(out_valid), 32'd1);
        chk("ill_next_addr", 32'(out_addr), 32'd0);

        // illegal accepted while draining: out_valid falls
        drive(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        step(); idle();
        chk("ill_drain_valid", 32'(out_valid), 32'd0);

        // address load and wrap
        do_reset();
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        addr_load = 1'b1; addr_value = 16'h0100;
        step(); addr_load = 1'b0;
        chk("load_addr", 32'(out_addr), 32'h100);
        step();
        chk("load_next", 32'(out_addr), 32'h104);
        addr_load = 1'b1; addr_value = 16'hFFFC;
        step(); addr_load = 1'b0;
        chk("wrap_top", 32'(out_addr), 32'hFFFC);
        step(); idle();
        chk("wrap_zero", 32'(out_addr), 32'h0);

        // more formats: beq x1,x2,-4 ; lui x5,0x12345 ; slli x1,x1,3 ; srai x2,x3,4
        do_reset();
        drive(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        step();
        chk("beq_inst", out_inst, 32'hFE208EE3);
        drive(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        step();
        chk("lui_inst", out_inst, 32'h123452B7);
        drive(7'h13, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 32'd3);
        step();
        chk("slli_inst", out_inst, 32'h00309093);
        drive(7'h13, 3'd5, 7'h20, 5'd2, 5'd3, 5'd0, 32'd4);
        step(); idle();
        chk("srai_inst", out_inst, 32'h4041D113);
        chk("srai_addr", 32'(out_addr), 32'd12);

        // out-of-range immediate
        do_reset();
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        step(); idle();
`ifdef IMM_CHECK_EN
        chk("imm4096_err", 32'(err), 32'd1);
        chk("imm4096_valid", 32'(out_valid), 32'd0);
`else
        chk("imm4096_err", 32'(err), 32'd0);
        chk("imm4096_valid", 32'(out_valid), 32'd1);
        chk("imm4096_inst", out_inst, 32'h00000093);
`endif

        // err_cnt saturation
        do_reset();
        drive(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 260; i++) step();
        idle();
        chk("errcnt_sat", 32'(err_cnt), 32'd255);

        // reset while a word is held
        do_reset();
        out_ready = 1'b0;
        drive(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        step(); idle();
        chk("held_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_inst", out_inst, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction encoder: the inverse of the CPU's instruction decoder. It accepts decoded instruction fields (opcode, funct3/funct7, register numbers, immediate) over a valid/ready handshake and packs them into 32-bit machine words. Each word is tagged with a sequential instruction-memory byte address. The block sits in front of instruction memory as the program-load/self-test path, so decoder round-trip tests and boot images can be generated in hardware.

## Interface
Parameters:
- ADDR_W, 16, width of instruction address counter (byte address)
- RESET_ADDR, 0, counter value after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_op  in  7  opcode (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP codes from define.vh)
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (OP, and OPIMM shifts only)
- in_rd / in_rs1 / in_rs2  in  5 each  register numbers
- in_imm  in  32  immediate, same layout as the decoder's imm output (sign-extended, B/J byte offsets)
- addr_load  in  1  load address counter
- addr_value  in  ADDR_W  value for addr_load
- out_valid  out  1  out_inst/out_addr valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address assigned to out_inst
- err  out  1  one-cycle pulse: bundle rejected
- err_cnt  out  8  saturating reject count

## Operation
- Single output register stage: in_ready = !out_valid || out_ready. Bundle is accepted when in_valid && in_ready.
- Formats:
  - OP: R-type {funct7,rs2,rs1,funct3,rd,op}.
  - OPIMM with funct3 001/101: {funct7, imm[4:0], rs1, funct3, rd, op}.
  - Other OPIMM, LOAD, JALR: I-type imm[11:0].
  - STORE: S-type {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - BRANCH: B-type {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
  - LUI/AUIPC: U-type {imm[31:12],rd,op}.
  - JAL: J-type {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Fields not used by a format are ignored (e.g. in_rs2 for I-type).
- Illegal bundles: any other opcode, or (with the Configuration feature) an out-of-range immediate.
  - Not emitted; err pulses in the acceptance cycle; err_cnt increments, saturating at 255.
  - Address counter unchanged. in_ready behaves as for a legal bundle.
- Address counter:
  - On accepting a legal bundle, the current value goes into out_addr and the counter advances by 4, wrapping modulo 2^ADDR_W.
  - addr_load has priority. If it coincides with a legal acceptance, that bundle gets addr_value and the counter becomes addr_value+4.

## Timing
- Reset values: out_valid 0, out_inst 0, out_addr 0, err 0, err_cnt 0, counter RESET_ADDR; in_ready 1 in the first cycle after reset.
- Latency: bundle accepted in cycle N appears on out_valid/out_inst/out_addr in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, outputs hold stable, in_ready=0 and nothing is accepted.
- Simultaneous drain and accept: the output register is replaced, with no bubble.
- Illegal bundle accepted while out_valid && out_ready: out_valid falls to 0 next cycle.
- rst mid-transfer discards the held word; no partial output.

## Configuration
- IMM_CHECK_EN defined:
  - Reject immediates that do not round-trip:
    - I/S: not the sign-extension of imm[11:0].
    - B: not sign-extended from imm[12], or imm[0]≠0.
    - J: not sign-extended from imm[20], or imm[0]≠0.
    - U: imm[11:0]≠0.
    - Shifts: imm[31:5]≠0.
  - Rejected bundles are handled as illegal.
- IMM_CHECK_EN undefined: no check; fields are silently truncated as in Operation.

## Test plan
- Reset, then addi x1,x0,5 (OPIMM,f3=0,rd=1,rs1=0,imm=5) -> next cycle out_inst=0x00500093, out_addr=0.
- Back-to-back add x3,x1,x2 then sw x2,8(x1), out_ready=1 -> 0x002081B3 @0, 0x0020A423 @4, no bubble.
- jal x1,+8 with out_ready=0 for 3 cycles -> 0x008000EF held stable, in_ready=0 throughout, released on out_ready=1.
- in_op=7'h7F -> err pulse, err_cnt=1, no out_valid, next legal bundle gets the unchanged address.
- addr_load with addr_value=0x100 coinciding with a legal accept -> out_addr=0x100, following instruction @0x104; counter at 0xFFFC wraps to 0.
- addi imm=4096: with IMM_CHECK_EN -> err, no output; without -> out_inst=0x00000093.
